search_ctrl: RTL and testbench
==============================

SEARCH_CTRL -- requirements
Module: search_ctrl

Interface
REQ-001 Parameter A, default 8, address width of the searched memory.
REQ-002 Parameter LAST_ADDR, default 2**A-1, highest address searched.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new search; sampled only in IDLE.
REQ-006 match  input  1  compare-stage equal flag (key word == memory word).
REQ-007 mismatch  input  1  compare-stage not-equal flag.
REQ-008 key_load  output  1  load strobe to the compare stage key register.
REQ-009 word_load  output  1  load strobe to the compare stage memory-word register.
REQ-010 mem_addr  output  A  read address to synchronous memory (1-cycle read latency).
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse at search completion.
REQ-013 found  output  1  last search hit; valid from done, held until next accepted start.
REQ-014 hit_addr  output  A  address of first hit; valid when found=1, held like found.
REQ-015 err  output  1  last search aborted on inconsistent match/mismatch; held like found.

Function
REQ-016 FSM states SHALL be IDLE, KEY, FETCH, LOAD, CHECK, DONE.
REQ-017 IDLE: start=1 -> KEY; clear found, err, hit_addr to 0; address counter to 0.
REQ-018 start while busy SHALL be ignored, not queued.
REQ-019 KEY: key_load=1 for exactly one cycle -> FETCH.
REQ-020 FETCH: mem_addr presents counter value -> LOAD.
REQ-021 LOAD: word_load=1 for exactly one cycle (memory data valid) -> CHECK.
REQ-022 CHECK: match=1, mismatch=0 -> DONE, found=1, hit_addr=counter.
REQ-023 CHECK: match=0, mismatch=1, counter==LAST_ADDR -> DONE, found=0.
REQ-024 CHECK: match=0, mismatch=1, counter<LAST_ADDR -> counter+1, FETCH.
REQ-025 CHECK: match==mismatch -> DONE, err=1, found=0, hit_addr=counter.
REQ-026 Counter SHALL never wrap; LAST_ADDR=2**A-1 terminates without overflow.
REQ-027 DONE: done=1 for one cycle -> IDLE unconditionally; start in DONE ignored.
REQ-028 Latency: start sampled at edge 0, hit at address n -> done high in cycle 3n+5.
REQ-029 match/mismatch SHALL be ignored in every state except CHECK.
REQ-030 mem_addr SHALL equal the counter in all states (0 in IDLE after reset).
REQ-031 key_load and word_load SHALL never be high in the same cycle.

Reset
REQ-032 reset SHALL override all inputs, including mid-search, and return to IDLE next edge.
REQ-033 Reset values: busy=0, done=0, found=0, err=0, key_load=0, word_load=0, hit_addr=0, mem_addr=0.

Structure
REQ-034 State encoding constants and default A SHALL reside in shared package search_pkg.
REQ-035 Address counter SHALL be a sub-module addr_counter (clear, increment, terminal flag).
REQ-036 Strobes SHALL be decoded from state only; no combinational path from match/mismatch to outputs.

Verification
REQ-037 Key 0x5A, memory[3]=0x5A, A=8 -> done in cycle 14, found=1, hit_addr=3, err=0.
REQ-038 Key absent, LAST_ADDR=15 -> done in cycle 50, found=0, mem_addr swept 0..15 once.
REQ-039 Hit at address 0 -> done in cycle 5, found=1, hit_addr=0; start in DONE ignored.
REQ-040 match=mismatch=1 forced at address 2 CHECK -> done, err=1, found=0, hit_addr=2.
REQ-041 reset asserted during LOAD of address 7 -> next cycle IDLE, all outputs at reset values.
REQ-042 start pulsed every cycle throughout search -> exactly one KEY strobe, one done pulse.

Source files
------------

// File: rtl/search_pkg.sv
// Shared definitions for the search controller: FSM encoding and default width.
package search_pkg;

  localparam int A_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KEY   = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/addr_counter.sv
// Search address counter: synchronous clear, increment that saturates at LAST,
// and a terminal flag so the controller can stop without the counter wrapping.
module addr_counter #(
  parameter int           A    = 8,
  parameter logic [A-1:0] LAST = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [A-1:0] cnt,
  output logic         last
);

  assign last = (cnt == LAST);

  // Count register; an increment requested at the terminal value is dropped.
  always_ff @(posedge clk) begin
    if (reset || clear)  cnt <= '0;
    else if (inc && !last) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/search_ctrl.sv
// Linear search controller: loads a key, then walks memory from address 0 to
// LAST_ADDR comparing each word, stopping at the first hit, at the last
// address, or on an inconsistent match/mismatch pair from the compare stage.
module search_ctrl
  import search_pkg::*;
#(
  parameter int A         = A_DEF,
  parameter int LAST_ADDR = 2**A - 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         match,
  input  logic         mismatch,
  output logic         key_load,
  output logic         word_load,
  output logic [A-1:0] mem_addr,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [A-1:0] hit_addr,
  output logic         err
);

  localparam logic [A-1:0] LAST = LAST_ADDR[A-1:0];

  state_t       state, nxt;
  logic         cnt_clear, cnt_inc, term;
  logic [A-1:0] cnt;

  // Compare flags only matter in CHECK; decoded here for readability.
  logic is_hit, is_bad;
  assign is_hit = match & ~mismatch;
  assign is_bad = (match == mismatch);

  addr_counter #(.A(A), .LAST(LAST)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (term)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state and counter control.
  always_comb begin
    nxt       = state;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE:  if (start) begin nxt = KEY; cnt_clear = 1'b1; end
      KEY:   nxt = FETCH;
      FETCH: nxt = LOAD;
      LOAD:  nxt = CHECK;
      CHECK: begin
        if (!is_hit && !is_bad && !term) begin
          cnt_inc = 1'b1;
          nxt     = FETCH;
        end else begin
          nxt = DONE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Result registers: cleared on an accepted start, written once in the final CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      found    <= 1'b0;
      err      <= 1'b0;
      hit_addr <= '0;
    end else if (state == IDLE && start) begin
      found    <= 1'b0;
      err      <= 1'b0;
      hit_addr <= '0;
    end else if (state == CHECK) begin
      if (is_bad) begin
        err      <= 1'b1;
        hit_addr <= cnt;
      end else if (is_hit) begin
        found    <= 1'b1;
        hit_addr <= cnt;
      end
    end
  end

  // Strobes come from state alone so compare flags never reach outputs combinationally.
  assign key_load  = (state == KEY);
  assign word_load = (state == LOAD);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mem_addr  = cnt;

endmodule

// File: tb/tb_search_ctrl.sv
// Directed bench for search_ctrl with a behavioural compare stage and
// synchronous memory (1-cycle read latency) around the controller.
module tb_search_ctrl;

  localparam int A = 8;

  logic         clk = 1'b0;
  logic         reset, start;
  logic         match, mismatch;
  logic         key_load, word_load, busy, done, found, err;
  logic [A-1:0] mem_addr, hit_addr;

  // Compare-stage model
  logic [7:0]   mem [0:255];
  logic [7:0]   key, key_reg, mem_q, word_reg;
  logic         force_bad;
  logic [A-1:0] force_addr;

  int checks = 0;
  int errors = 0;

  search_ctrl #(.A(A), .LAST_ADDR(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .match     (match),
    .mismatch  (mismatch),
    .key_load  (key_load),
    .word_load (word_load),
    .mem_addr  (mem_addr),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .hit_addr  (hit_addr),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_q <= mem[mem_addr];
    if (key_load)  key_reg  <= key;
    if (word_load) word_reg <= mem_q;
  end

  always_comb begin
    match    = (key_reg == word_reg);
    mismatch = !(key_reg == word_reg);
    if (force_bad && mem_addr == force_addr) begin
      match    = 1'b1;
      mismatch = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch a search from a negedge; returns the done cycle (cycle 1 follows
  // the edge that samples start), the key_load count and the LOAD addresses.
  int addr_log[$];
  task automatic run(input logic hold, output int dcyc, output int nkey);
    dcyc = -1;
    nkey = 0;
    addr_log.delete();
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (key_load)  nkey++;
      if (word_load) addr_log.push_back(int'(mem_addr));
      if (done) begin dcyc = c; break; end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  busy,      1'b0);
    chk({tag, "_done"},  done,      1'b0);
    chk({tag, "_found"}, found,     1'b0);
    chk({tag, "_err"},   err,       1'b0);
    chk({tag, "_kl"},    key_load,  1'b0);
    chk({tag, "_wl"},    word_load, 1'b0);
    chk({tag, "_hit"},   hit_addr,  8'd0);
    chk({tag, "_addr"},  mem_addr,  8'd0);
  endtask

  int  dc, nk, extra_done, extra_busy;
  logic sweep_ok;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[3]     = 8'h5A;
    mem[16]    = 8'h77;   // beyond LAST_ADDR, must never be reached
    key        = 8'h00;
    key_reg    = 8'hFF;
    word_reg   = 8'hEE;
    force_bad  = 1'b0;
    force_addr = '0;
    start      = 1'b0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);

    // Hit at address 3
    key = 8'h5A;
    run(1'b0, dc, nk);
    chk("hit3_cycle", dc, 14);
    chk("hit3_found", found, 1'b1);
    chk("hit3_addr",  hit_addr, 8'd3);
    chk("hit3_err",   err, 1'b0);
    chk("hit3_busy",  busy, 1'b1);
    chk("hit3_nkey",  nk, 1);
    @(negedge clk);
    chk("hit3_done_pulse", done, 1'b0);
    chk("hit3_idle",  busy, 1'b0);
    chk("hit3_held",  found, 1'b1);
    chk("hit3_hheld", hit_addr, 8'd3);
    @(negedge clk);

    // Key absent: sweep 0..15 once, stop at LAST_ADDR
    key = 8'h77;
    run(1'b0, dc, nk);
    chk("miss_cycle", dc, 50);
    chk("miss_found", found, 1'b0);
    chk("miss_err",   err, 1'b0);
    chk("miss_addr",  mem_addr, 8'd15);
    sweep_ok = (addr_log.size() == 16);
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] != i) sweep_ok = 1'b0;
    chk("miss_sweep", sweep_ok, 1'b1);
    @(negedge clk);
    @(negedge clk);

    // Hit at the last address
    mem[15] = 8'h77;
    run(1'b0, dc, nk);
    chk("last_cycle", dc, 50);
    chk("last_found", found, 1'b1);
    chk("last_addr",  hit_addr, 8'd15);
    mem[15] = 8'h00;
    @(negedge clk);
    @(negedge clk);

    // Hit at address 0; start raised in DONE must be ignored
    mem[0] = 8'h33;
    key    = 8'h33;
    run(1'b0, dc, nk);
    chk("hit0_cycle", dc, 5);
    chk("hit0_found", found, 1'b1);
    chk("hit0_addr",  hit_addr, 8'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hit0_done_start_ign", busy, 1'b0);
    @(negedge clk);
    chk("hit0_still_idle", busy, 1'b0);
    chk("hit0_held", found, 1'b1);
    mem[0] = 8'h00;

    // Inconsistent flags at address 2
    key        = 8'h99;
    force_bad  = 1'b1;
    force_addr = 8'd2;
    run(1'b0, dc, nk);
    chk("err_cycle", dc, 11);
    chk("err_err",   err, 1'b1);
    chk("err_found", found, 1'b0);
    chk("err_addr",  hit_addr, 8'd2);
    force_bad = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // start held high through the whole search
    key = 8'h5A;
    run(1'b1, dc, nk);
    start = 1'b0;
    chk("hold_cycle", dc, 14);
    chk("hold_nkey",  nk, 1);
    chk("hold_found", found, 1'b1);
    extra_done = 0;
    extra_busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    chk("hold_one_done", extra_done, 0);
    chk("hold_no_requeue", extra_busy, 0);

    // Reset during LOAD of address 7
    key = 8'h77;
    start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (word_load && mem_addr == 8'd7) break;
    end
    chk("rst_mid_at_load7", {word_load, mem_addr}, {1'b1, 8'd7});
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_stay_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
